ysyx_mdu: RTL and testbench
===========================

YSYX_MDU -- requirements
Module: ysyx_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (>=8, even).
REQ-002 SHALL have parameter TAGW, default 5, destination-register tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous abort of any operation in progress.
REQ-006 SHALL have port in_valid  input  1  request valid.
REQ-007 SHALL have port in_ready  output  1  unit can accept request.
REQ-008 SHALL have port op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 SHALL have port src_a  input  XLEN  operand A (multiplicand/dividend).
REQ-010 SHALL have port src_b  input  XLEN  operand B (multiplier/divisor).
REQ-011 SHALL have port rd_in  input  TAGW  tag carried with request.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  XLEN  operation result.
REQ-015 SHALL have port rd_out  output  TAGW  tag of the request producing result.
REQ-016 SHALL have port busy  output  1  high in BUSY or DONE.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; in_ready = (state==IDLE).
REQ-018 SHALL accept a request on posedge with in_valid & in_ready, latching op, operands, rd_in.
REQ-019 SHALL compute iteratively, one bit per cycle: shift-add multiply (2*XLEN product), restoring divide on magnitudes.
REQ-020 SHALL, for accept at cycle T, stay in BUSY for exactly XLEN cycles and assert out_valid from T+XLEN+1.
REQ-021 SHALL hold result, rd_out, out_valid stable in DONE until out_valid & out_ready, then go IDLE next cycle.
REQ-022 SHALL not accept a new request in the cycle the result is consumed (no back-to-back overlap).
REQ-023 SHALL return MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits with operands signed/signed, signed/unsigned, unsigned/unsigned.
REQ-024 SHALL apply sign correction to signed divide: quotient negative iff operand signs differ, remainder takes dividend sign.
REQ-025 SHALL, divisor 0: quotient all ones (DIV/DIVU), remainder = src_a (REM/REMU).
REQ-026 SHALL, DIV with src_a = most-negative and src_b = -1: quotient = most-negative, remainder 0.
REQ-027 SHALL, on flush, go IDLE next cycle from any state, drop the result, deassert out_valid; flush wins over in_valid/out_ready in the same cycle.
REQ-028 SHALL keep result and rd_out at last value (or zero after reset) when out_valid is low.

Reset
REQ-029 SHALL, on rst_n low, immediately go IDLE and clear out_valid, result, rd_out, busy, counter, all datapath registers to 0.
REQ-030 SHALL abandon any operation in progress on reset assertion; in_ready = 1 while rst_n low is not required (0 allowed), and SHALL be 1 on first posedge after release.

Configuration
REQ-031 SHALL, with YSYX_MDU_EARLY_EN defined, complete divisor-0, REQ-026 overflow, and any multiply with a zero operand in one cycle: out_valid at T+1, same values as REQ-023..026.
REQ-032 SHALL, without YSYX_MDU_EARLY_EN, use the full XLEN-cycle latency for every operation, results unchanged.

Verification
REQ-033 SHALL cover MUL: src_a=7, src_b=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB, rd_out = rd_in, out_valid at T+33.
REQ-034 SHALL cover MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-035 SHALL cover DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-036 SHALL cover DIV x/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000; latency T+1 with YSYX_MDU_EARLY_EN, T+33 without.
REQ-037 SHALL cover backpressure: out_ready low 10 cycles after out_valid -> result stable, in_ready 0; then out_ready 1 -> in_ready 1 next cycle.
REQ-038 SHALL cover flush at T+5 of a DIVU and rst_n low at T+10 of a MUL -> no out_valid, IDLE next cycle, subsequent MUL 3x4 -> 12.

Source files
------------

// File: rtl/ysyx_mdu.sv
// ysyx_mdu: iterative RV-style multiply/divide unit, one bit per cycle, ready/valid handshake.
// Define YSYX_MDU_EARLY_EN to finish divide-by-zero, signed overflow and zero-operand multiply in one cycle.
module ysyx_mdu #(
   parameter int XLEN = 32,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic [TAGW-1:0] rd_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [TAGW-1:0] rd_out,
   output logic            busy
);
   localparam int CW = $clog2(XLEN);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [2*XLEN-1:0] p, p_nxt, p_init;
   logic [XLEN-1:0] b, mag_a, mag_b;
   logic [XLEN:0] sum, diff;
   logic [CW-1:0] cnt;
   logic [TAGW-1:0] tag_r;
   logic [2:0] op_r;
   logic sa_r, sb_r, dz_r, a_sgn, b_sgn, sa, sb, dz, early, fire, last;

   // p holds magnitudes; sign correction and divide-by-zero are applied only when the result is formed
   function automatic logic [XLEN-1:0] fin(input logic [2:0] o, input logic [2*XLEN-1:0] v,
                                           input logic s_a, input logic s_b, input logic z);
      logic [2*XLEN-1:0] full;
      logic [XLEN-1:0] q, r;
      full = (s_a ^ s_b) ? -v : v;
      q = (s_a ^ s_b) ? -v[XLEN-1:0] : v[XLEN-1:0];
      r = s_a ? -v[2*XLEN-1:XLEN] : v[2*XLEN-1:XLEN];
      if (!o[2]) return (o[1:0] == 2'd0) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];
      return o[1] ? r : (z ? '1 : q);
   endfunction

   assign fire      = in_valid & in_ready;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign busy      = state != IDLE;

   always_comb begin
      a_sgn = (op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6);
      b_sgn = (op == 3'd1) | (op == 3'd4) | (op == 3'd6);
      sa = a_sgn & src_a[XLEN-1];
      sb = b_sgn & src_b[XLEN-1];
      mag_a = sa ? -src_a : src_a;
      mag_b = sb ? -src_b : src_b;
      dz = src_b == '0;
`ifdef YSYX_MDU_EARLY_EN
      early = op[2] ? (dz | (sa & sb & (src_a == {1'b1, {(XLEN-1){1'b0}}}) & (src_b == '1)))
                    : ((src_a == '0) | dz);
`else
      early = 1'b0;
`endif
      p_init = (early & op[2] & dz) ? {mag_a, {XLEN{1'b1}}}
             : (early & ~op[2]) ? '0 : {{XLEN{1'b0}}, mag_a};
      sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b} : '0);
      diff = p[2*XLEN-1:XLEN-1] - {1'b0, b};
      p_nxt = op_r[2] ? (diff[XLEN] ? {p[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1})
                      : {sum, p[XLEN-1:1]};
      last = cnt == CW'(XLEN - 1);
   end

   always_comb begin
      state_nxt = flush ? IDLE
                : (state == IDLE) ? (in_valid ? (early ? DONE : BUSY) : IDLE)
                : (state == BUSY) ? (last ? DONE : BUSY)
                : (out_ready ? IDLE : DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p <= '0;
         b <= '0;
         cnt <= '0;
         tag_r <= '0;
         op_r <= '0;
         sa_r <= 1'b0;
         sb_r <= 1'b0;
         dz_r <= 1'b0;
         result <= '0;
         rd_out <= '0;
      end else if (!flush) begin
         if (fire) begin
            p <= p_init;
            b <= mag_b;
            cnt <= '0;
            tag_r <= rd_in;
            op_r <= op;
            sa_r <= sa;
            sb_r <= sb;
            dz_r <= dz;
            if (early) begin
               result <= fin(op, p_init, sa, sb, dz);
               rd_out <= rd_in;
            end
         end else if (state == BUSY) begin
            p <= p_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
               result <= fin(op_r, p_nxt, sa_r, sb_r, dz_r);
               rd_out <= tag_r;
            end
         end
      end
   end
endmodule

// File: tb/tb_ysyx_mdu.sv
// tb_ysyx_mdu: directed and random checks of ysyx_mdu against an arithmetic reference model.
// Honours YSYX_MDU_EARLY_EN when choosing the expected latency.
module tb_ysyx_mdu;
   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, busy;
   logic [2:0] op = '0;
   logic [31:0] src_a = '0, src_b = '0, result;
   logic [4:0] rd_in = '0, rd_out;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   ysyx_mdu dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .rd_in(rd_in), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .rd_out(rd_out), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd0: t = {32'b0, a} * {32'b0, b};
         3'd1: t = sa * sb;
         3'd2: t = sa * longint'({32'b0, b});
         3'd3: t = {32'b0, a} * {32'b0, b};
         default: t = '0;
      endcase
      case (o)
         3'd0: return t[31:0];
         3'd1, 3'd2, 3'd3: return t[63:32];
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : 32'(sa % sb);
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // cycles between the accepting edge and the edge that raises out_valid
   function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      bit fast;
      fast = o[2] ? (b == 0 || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                  : (a == 0 || b == 0);
`ifdef YSYX_MDU_EARLY_EN
      return fast ? 0 : 32;
`else
      return fast ? 32 : 32;
`endif
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_issue", in_ready, 1'b1);
      op = o; src_a = a; src_b = b; rd_in = r; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] r, input bit bp);
      int n = 0;
      logic [31:0] exp;
      exp = model(o, a, b);
      issue(o, a, b, r);
      while (!out_valid && n < 40) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'(exp_lat(o, a, b)));
      chk({tag, "_res"}, result, exp);
      chk({tag, "_rd"}, rd_out, r);
      chk({tag, "_noaccept"}, in_ready, 1'b0);
      if (bp) begin
         for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_bp_hold"}, {out_valid, in_ready, rd_out, result}, {1'b1, 1'b0, r, exp});
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk({tag, "_drain"}, {in_ready, out_valid, busy}, 3'b100);
   endtask

   initial begin
      int hits;
      repeat (2) @(posedge clk);
      #1 chk("reset_state", {out_valid, busy, result, rd_out}, '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_reset", in_ready, 1'b1);

      run("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b0);
      run("mulhu_ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
      run("mulh_ones", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
      run("mulhsu", 3'd2, 32'h8000_0001, 32'hF000_0000, 5'd5, 1'b0);
      run("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
      run("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b0);
      run("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd8, 1'b0);
      run("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd10, 1'b0);
      run("div_x_0", 3'd4, 32'h1234_5678, 32'd0, 5'd11, 1'b0);
      run("rem_5_0", 3'd6, 32'd5, 32'd0, 5'd12, 1'b0);
      run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
      run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
      run("mul_zero", 3'd0, 32'h0, 32'hDEAD_BEEF, 5'd15, 1'b0);
      run("backpressure", 3'd5, 32'd1000, 32'd33, 5'd16, 1'b1);

      issue(3'd5, 32'd100, 32'd7, 5'd17);
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_idle", {in_ready, out_valid, busy}, 3'b100);
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1 hits += int'(out_valid);
      end
      chk("flush_no_valid", 64'(hits), 64'd0);

      issue(3'd0, 32'd123, 32'd456, 5'd18);
      repeat (9) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset", {out_valid, busy, result, rd_out}, '0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_rst", in_ready, 1'b1);
      run("mul_3x4", 3'd0, 32'd3, 32'd4, 5'd19, 1'b0);
      chk("mul_3x4_const", result, 32'd12);

      for (int i = 0; i < 24; i++) begin
         logic [2:0] o;
         logic [31:0] a, b;
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: a = '0;
            4: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run("rand", o, a, b, 5'($urandom), 1'($urandom_range(0, 5) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
